// File: rtl/loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : loader_pkg
// Description : Shared definitions for the boot-time program loader: loader
//               state encoding, frame-field sizes, and the word and address
//               widths also used by instruction_memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

   // Datapath widths shared with instruction_memory
   localparam int C_WORD_WIDTH      = 32;
   localparam int C_ADDR_WIDTH      = 64;

   // Frame layout: LEN_LO, LEN_HI, payload words LSB first, then CHK
   localparam int C_BYTES_PER_WORD  = 4;
   localparam int C_LEN_FIELD_BYTES = 2;
   localparam int C_LEN_FIELD_WIDTH = 8 * C_LEN_FIELD_BYTES;
   localparam int C_CHK_FIELD_BYTES = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_LO  = 3'd1,
      ST_LEN_HI  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHECK   = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

endpackage : loader_pkg

`default_nettype wire

// File: rtl/word_assembler.sv
//------------------------------------------------------------------------------
// Module      : word_assembler
// Description : Collects four bytes into a little-endian 32-bit word. The
//               fourth byte is announced combinationally on word_last (so
//               the caller can act in the same cycle), and the completed word
//               is presented one cycle later on word_valid/word.
// Ports       : clock, reset  - clock and synchronous active-high reset
//               clear         - restart byte position at 0 (new load)
//               byte_en       - a byte is accepted this cycle
//               byte_data     - the byte
//               word_last     - this byte_en completes a word
//               word_valid    - one-cycle pulse, word holds the new value
//               word          - last completed word
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_assembler
   import loader_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    byte_en,
   input  logic [7:0]              byte_data,
   output logic                    word_last,
   output logic                    word_valid,
   output logic [C_WORD_WIDTH-1:0] word
);

   logic [1:0]              r_cnt;
   logic [C_WORD_WIDTH-1:0] r_partial;
   logic [C_WORD_WIDTH-1:0] r_word;
   logic                    r_valid;

   assign word_last  = byte_en && (r_cnt == 2'd3);
   assign word_valid = r_valid;
   assign word       = r_word;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt     <= 2'd0;
         r_partial <= '0;
         r_word    <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (clear) begin
            r_cnt <= 2'd0;
         end else if (byte_en) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               // Fourth byte goes straight into the top lane of the output
               r_word  <= {byte_data, r_partial[23:0]};
               r_valid <= 1'b1;
            end else begin
               r_partial[{r_cnt, 3'b000} +: 8] <= byte_data;
            end
         end
      end
   end

endmodule : word_assembler

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// Module      : program_loader
// Description : Boot loader in front of the core's instruction memory. Parses
//               a LEN_LO/LEN_HI/payload/CHK byte frame, writes each assembled
//               word to BASE_ADDR + 4*index and holds the core in reset until
//               the XOR checksum of the payload matches.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               start                   - begin a load (IDLE/DONE/ERROR only)
//               byte_valid/byte_ready   - stream handshake, byte_data payload
//               imem_we/addr/wdata      - instruction memory write port
//               core_reset              - low only once a verified image exists
//               busy/done/error         - load status
//               words_loaded            - words written in this load
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module program_loader
   import loader_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int          MAX_WORDS = 1024,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   output logic                    byte_ready,
   output logic                    imem_we,
   output logic [C_ADDR_WIDTH-1:0] imem_addr,
   output logic [C_WORD_WIDTH-1:0] imem_wdata,
   output logic                    core_reset,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [CNT_WIDTH-1:0]    words_loaded
);

   loader_state_t                  r_state;
   loader_state_t                  w_next;

   logic [7:0]                     r_len_lo;
   logic [CNT_WIDTH-1:0]           r_len;
   logic [CNT_WIDTH-1:0]           r_words;
   logic [7:0]                     r_chk;
   logic [C_ADDR_WIDTH-1:0]        r_addr;

   logic                           w_xfer;
   logic                           w_start_load;
   logic                           w_byte_en;
   logic                           w_word_last;
   logic                           w_final_word;
   logic                           w_oversize;
   logic [C_LEN_FIELD_WIDTH-1:0]   w_len_field;

   assign byte_ready   = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                         (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
   assign busy         = byte_ready;
   assign done         = (r_state == ST_DONE);
   assign error        = (r_state == ST_ERROR);
   assign core_reset   = (r_state != ST_DONE);

   assign w_xfer       = byte_valid && byte_ready;
   assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
   assign w_byte_en    = w_xfer && (r_state == ST_PAYLOAD);
   assign w_len_field  = {byte_data, r_len_lo};
   assign w_oversize   = {16'h0, w_len_field} > 32'(MAX_WORDS);
   assign w_final_word = w_word_last && ((r_words + CNT_WIDTH'(1)) == r_len);

   word_assembler u_word_assembler (
      .clock      (clock),
      .reset      (reset),
      .clear      (w_start_load),
      .byte_en    (w_byte_en),
      .byte_data  (byte_data),
      .word_last  (w_word_last),
      .word_valid (imem_we),
      .word       (imem_wdata)
   );

   assign imem_addr    = r_addr;
   assign words_loaded = r_words;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_start_load) w_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (w_xfer) w_next = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (w_xfer) begin
               if (w_oversize)              w_next = ST_ERROR;
               else if (w_len_field == '0)  w_next = ST_CHECK;
               else                         w_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (w_final_word) w_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_xfer) w_next = (byte_data == r_chk) ? ST_DONE : ST_ERROR;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_len_lo <= 8'h00;
         r_len    <= '0;
         r_words  <= '0;
         r_chk    <= 8'h00;
         r_addr   <= '0;
      end else begin
         r_state <= w_next;
         if (w_start_load) begin
            r_words <= '0;
            r_chk   <= 8'h00;
         end
         if (w_xfer && (r_state == ST_LEN_LO)) r_len_lo <= byte_data;
         if (w_xfer && (r_state == ST_LEN_HI)) r_len    <= CNT_WIDTH'(w_len_field);
         if (w_byte_en) begin
            r_chk <= r_chk ^ byte_data;
            if (w_word_last) begin
               // Address is captured with the word so it lines up with imem_we
               r_addr  <= BASE_ADDR + (C_ADDR_WIDTH'(r_words) << 2);
               r_words <= r_words + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule : program_loader

`default_nettype wire

// File: tb/tb_program_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;

   logic        clock;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int checks   = 0;
   int failures = 0;

   logic [63:0] wr_addr [0:31];
   logic [31:0] wr_data [0:31];
   int          wr_count = 0;
   int          base;

   logic [7:0]  frame1 [0:10];

   program_loader #(
      .BASE_ADDR (64'h0),
      .MAX_WORDS (1024),
      .CNT_WIDTH (16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Write monitor, sampled away from the active edge
   always @(negedge clock) begin
      if (imem_we) begin
         if (wr_count < 32) begin
            wr_addr[wr_count] = imem_addr;
            wr_data[wr_count] = imem_wdata;
         end
         wr_count = wr_count + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"},   byte_ready,   0);
      check({tag, "_imem_we"},      imem_we,      0);
      check({tag, "_imem_addr"},    imem_addr,    0);
      check({tag, "_imem_wdata"},   imem_wdata,   0);
      check({tag, "_core_reset"},   core_reset,   1);
      check({tag, "_busy"},         busy,         0);
      check({tag, "_done"},         done,         0);
      check({tag, "_error"},        error,        0);
      check({tag, "_words_loaded"}, words_loaded, 0);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_byte_ready", byte_ready, 1);
      check("start_busy", busy, 1);
      check("start_words_cleared", words_loaded, 0);
   endtask

   // Present one byte after 'gap' idle cycles; returns just after it transfers
   task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
      int t;
      for (int g = 0; g < gap; g++) @(negedge clock);
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = b;
      if (with_start) start = 1'b1;
      t = 0;
      while (!byte_ready && t < 20) begin
         @(negedge clock);
         t++;
      end
      if (!byte_ready) check("handshake_ready", byte_ready, 1);
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic send_frame1(input logic [7:0] chk, input bit gaps, input bit mid_start);
      for (int i = 0; i < 11; i++) begin
         send_byte((i == 10) ? chk : frame1[i],
                   gaps ? int'($urandom_range(0, 3)) : 0,
                   mid_start && (i == 6));
      end
   endtask

   task automatic check_frame1_writes(input string tag, input int b);
      check({tag, "_nwrites"}, 64'(wr_count - b), 2);
      check({tag, "_addr0"},   wr_addr[b],       64'h0);
      check({tag, "_data0"},   wr_data[b],       32'h00000513);
      check({tag, "_addr1"},   wr_addr[b+1],     64'h4);
      check({tag, "_data1"},   wr_data[b+1],     32'h00100093);
   endtask

   initial begin
      frame1[0] = 8'h02; frame1[1] = 8'h00;
      frame1[2] = 8'h13; frame1[3] = 8'h05; frame1[4] = 8'h00; frame1[5] = 8'h00;
      frame1[6] = 8'h93; frame1[7] = 8'h00; frame1[8] = 8'h10; frame1[9] = 8'h00;
      frame1[10] = 8'h95;

      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("rst");
      @(negedge clock);
      reset = 1'b0;

      // Good two-word image, back-to-back bytes
      base = wr_count;
      pulse_start();
      send_frame1(8'h95, 1'b0, 1'b0);
      check("good_done",       done,         1);
      check("good_core_reset", core_reset,   0);
      check("good_error",      error,        0);
      check("good_busy",       busy,         0);
      check("good_ready",      byte_ready,   0);
      check("good_words",      words_loaded, 2);
      check_frame1_writes("good", base);

      // Bad checksum: writes still land, core held in reset
      base = wr_count;
      pulse_start();
      send_frame1(8'h94, 1'b0, 1'b0);
      check("badchk_error",      error,        1);
      check("badchk_done",       done,         0);
      check("badchk_core_reset", core_reset,   1);
      check("badchk_words",      words_loaded, 2);
      check_frame1_writes("badchk", base);

      // Empty image
      base = wr_count;
      pulse_start();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      check("empty_in_check", done, 0);
      send_byte(8'h00, 0, 1'b0);
      check("empty_done",       done,       1);
      check("empty_core_reset", core_reset, 0);
      check("empty_nwrites",    64'(wr_count - base), 0);

      // Oversize length 1025
      base = wr_count;
      pulse_start();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h04, 0, 1'b0);
      check("oversize_error", error,      1);
      check("oversize_ready", byte_ready, 0);
      check("oversize_busy",  busy,       0);
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = 8'h13;
      repeat (4) @(negedge clock);
      check("oversize_still_not_ready", byte_ready, 0);
      check("oversize_still_error",     error,      1);
      byte_valid = 1'b0;
      check("oversize_nwrites", 64'(wr_count - base), 0);

      // Random gaps and an ignored start pulse mid-payload
      base = wr_count;
      pulse_start();
      send_frame1(8'h95, 1'b1, 1'b1);
      check("gaps_done",       done,         1);
      check("gaps_core_reset", core_reset,   0);
      check("gaps_words",      words_loaded, 2);
      check_frame1_writes("gaps", base);

      // Reset mid-payload, then a full reload
      pulse_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h13, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h93, 0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_reset_outputs("midrst");
      @(negedge clock);
      reset = 1'b0;
      base = wr_count;
      pulse_start();
      send_frame1(8'h95, 1'b0, 1'b0);
      check("reload_done",  done,         1);
      check("reload_words", words_loaded, 2);
      check_frame1_writes("reload", base);

      repeat (2) @(negedge clock);
      check("final_no_we", imem_we, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_program_loader

`default_nettype wire
